// File: rtl/lb_master_pkg.sv
// lb_master_pkg: command codes, timeout filler and FSM encoding shared by lb_master files
package lb_master_pkg;
   localparam logic [7:0]  CMD_WR       = 8'h57;
   localparam logic [7:0]  CMD_RD       = 8'h52;
   localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;
   localparam logic [2:0]  ST_IDLE      = 3'd0;
   localparam logic [2:0]  ST_ADDR      = 3'd1;
   localparam logic [2:0]  ST_DATA      = 3'd2;
   localparam logic [2:0]  ST_WR        = 3'd3;
   localparam logic [2:0]  ST_RD        = 3'd4;
   localparam logic [2:0]  ST_RD_WAIT   = 3'd5;
   localparam logic [2:0]  ST_TX        = 3'd6;
   typedef enum logic [2:0] {
      S_IDLE    = ST_IDLE,
      S_ADDR    = ST_ADDR,
      S_DATA    = ST_DATA,
      S_WR      = ST_WR,
      S_RD      = ST_RD,
      S_RD_WAIT = ST_RD_WAIT,
      S_TX      = ST_TX
   } state_t;
   function automatic logic is_cmd(input logic [7:0] b);
      return b == CMD_WR || b == CMD_RD;
   endfunction
endpackage

// File: rtl/lb_master_byte_ser.sv
// lb_byte_ser: sends a 32-bit word to the host as 4 bytes MSB first with strobes at least 2 cycles apart
module lb_byte_ser
   import lb_master_pkg::*;
(
   input  logic        clk_lb,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] din,
   input  logic        tx_busy,
   output logic [7:0]  tx_byte_d,
   output logic        tx_byte_rdy,
   output logic        done
);
   logic [31:0] r_sr;
   logic [2:0]  r_left;
   logic [7:0]  r_d;
   logic        r_rdy;
   logic        r_done;
   logic        w_emit;
   // a byte goes out only when the host is free and no strobe was issued last cycle
   assign w_emit = (r_left != 3'd0) && !tx_busy && !r_rdy;
   // shift register, bytes-left counter and registered strobe; done coincides with the last strobe
   always_ff @(posedge clk_lb) begin
      if (reset) begin
         r_sr   <= '0;
         r_left <= '0;
         r_d    <= '0;
         r_rdy  <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_rdy  <= w_emit;
         r_done <= w_emit && r_left == 3'd1;
         if (load) begin
            r_sr   <= din;
            r_left <= 3'd4;
         end else if (w_emit) begin
            r_d    <= r_sr[31:24];
            r_sr   <= {r_sr[23:0], 8'h00};
            r_left <= r_left - 3'd1;
         end
      end
   end
   assign tx_byte_d   = r_d;
   assign tx_byte_rdy = r_rdy;
   assign done        = r_done;
endmodule

// File: rtl/lb_master.sv
// lb_master: parses host write/read commands into single-beat local-bus cycles and returns read data
module lb_master
   import lb_master_pkg::*;
#(
   parameter int rd_timeout = 255,
   parameter int to_bits    = 8
) (
   input  logic        clk_lb,
   input  logic        reset,
   input  logic [7:0]  rx_byte_d,
   input  logic        rx_byte_rdy,
   input  logic        tx_busy,
   output logic [7:0]  tx_byte_d,
   output logic        tx_byte_rdy,
   output logic        lb_wr,
   output logic        lb_rd,
   output logic [31:0] lb_addr,
   output logic [31:0] lb_wr_d,
   input  logic [31:0] lb_rd_d,
   input  logic        lb_rd_rdy,
   output logic        rd_to_err
);
   localparam logic [to_bits-1:0] TO_LAST = to_bits'(rd_timeout - 1);
   state_t             r_state;
   logic               r_cmd_wr;
   logic [1:0]         r_bcnt;
   logic [to_bits-1:0] r_cnt;
   logic [31:0]        r_addr;
   logic [31:0]        r_wr_d;
   logic               r_wr;
   logic               r_rd;
   logic               w_wait;
   logic               w_hit;
   logic               w_load;
   logic               w_done;
   logic [31:0]        w_din;
   // counter reads k-1 on the k-th cycle after lb_rd, so the hit lands exactly rd_timeout cycles later
   assign w_wait    = r_state == S_RD_WAIT;
   assign w_hit     = r_cnt == TO_LAST;
   assign w_load    = w_wait && (lb_rd_rdy || w_hit);
   assign w_din     = lb_rd_rdy ? lb_rd_d : TIMEOUT_DATA;
   assign rd_to_err = w_wait && w_hit && !lb_rd_rdy;
   // command FSM: collects address/data bytes, issues one bus strobe, waits for read data, hands off to tx
   always_ff @(posedge clk_lb) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_cmd_wr <= 1'b0;
         r_bcnt   <= '0;
         r_cnt    <= '0;
         r_addr   <= '0;
         r_wr_d   <= '0;
         r_wr     <= 1'b0;
         r_rd     <= 1'b0;
      end else begin
         r_wr <= 1'b0;
         r_rd <= 1'b0;
         case (r_state)
            S_IDLE: if (rx_byte_rdy && is_cmd(rx_byte_d)) begin
               r_cmd_wr <= rx_byte_d == CMD_WR;
               r_bcnt   <= '0;
               r_state  <= S_ADDR;
            end
            S_ADDR: if (rx_byte_rdy) begin
               r_addr <= {r_addr[23:0], rx_byte_d};
               r_bcnt <= r_bcnt + 2'd1;
               if (r_bcnt == 2'd3) begin
                  r_state <= r_cmd_wr ? S_DATA : S_RD;
                  r_rd    <= !r_cmd_wr;
               end
            end
            S_DATA: if (rx_byte_rdy) begin
               r_wr_d <= {r_wr_d[23:0], rx_byte_d};
               r_bcnt <= r_bcnt + 2'd1;
               if (r_bcnt == 2'd3) begin
                  r_state <= S_WR;
                  r_wr    <= 1'b1;
               end
            end
            S_WR: r_state <= S_IDLE;
            S_RD: begin
               r_cnt   <= '0;
               r_state <= S_RD_WAIT;
            end
            S_RD_WAIT: begin
               r_cnt <= r_cnt + 1'b1;
               if (w_load) r_state <= S_TX;
            end
            S_TX: if (w_done) r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end
   lb_byte_ser u_ser (
      .clk_lb      (clk_lb),
      .reset       (reset),
      .load        (w_load),
      .din         (w_din),
      .tx_busy     (tx_busy),
      .tx_byte_d   (tx_byte_d),
      .tx_byte_rdy (tx_byte_rdy),
      .done        (w_done)
   );
   assign lb_addr = r_addr;
   assign lb_wr_d = r_wr_d;
   assign lb_wr   = r_wr;
   assign lb_rd   = r_rd;
endmodule

// File: doc/lb_master.md
# lb_master

Local-bus initiator that turns a host byte stream into single-beat `lb_wr` / `lb_rd` cycles on the `clk_lb` domain, and serializes read data back to the host. It sits between the UART/byte transport and the core wrapper, driving the same `lb_addr` / `lb_wr_d` / `lb_rd_d` / `lb_rd_rdy` bus that the SUMP2 control and data ports respond to.

## Interface
Parameters:
- `rd_timeout`, default 255: maximum `clk_lb` cycles to wait for `lb_rd_rdy` after `lb_rd`; legal range 1..2^`to_bits`-1.
- `to_bits`, default 8: width of the timeout counter.

Ports:
- `clk_lb`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `rx_byte_d`  in  8  received host byte.
- `rx_byte_rdy`  in  1  one-cycle strobe; `rx_byte_d` is valid on this cycle.
- `tx_busy`  in  1  transmitter cannot accept a byte.
- `tx_byte_d`  out  8  byte to host.
- `tx_byte_rdy`  out  1  one-cycle strobe; `tx_byte_d` is valid on this cycle.
- `lb_wr`  out  1  one-cycle write strobe.
- `lb_rd`  out  1  one-cycle read strobe.
- `lb_addr`  out  32  bus address; held stable until the next command loads a new one.
- `lb_wr_d`  out  32  write data; held stable like `lb_addr`.
- `lb_rd_d`  in  32  read data; valid when `lb_rd_rdy`=1.
- `lb_rd_rdy`  in  1  read-data strobe from the responder.
- `rd_to_err`  out  1  one-cycle pulse when a read times out.

## Operation
- Command bytes:
  - 0x57 (CMD_WR): followed by 4 address bytes, then 4 data bytes, all MSB first.
  - 0x52 (CMD_RD): followed by 4 address bytes, MSB first.
  - Any other byte in IDLE is discarded.
- States: IDLE, ADDR, DATA, WR, RD, RD_WAIT, TX.
- Transitions:
  - IDLE→ADDR on a command byte; the command is latched.
  - ADDR: shifts 4 bytes into `lb_addr`. After the 4th byte: →DATA for a write, →RD for a read.
  - DATA: shifts 4 bytes into `lb_wr_d`, then →WR.
  - WR: `lb_wr`=1 for exactly one cycle, then →IDLE.
  - RD: `lb_rd`=1 for exactly one cycle, the timeout counter clears, then →RD_WAIT.
  - RD_WAIT: on `lb_rd_rdy`=1, capture `lb_rd_d` into the tx shift register and →TX. If the counter reaches `rd_timeout` first, load 0xDEADBEEF, pulse `rd_to_err`, and →TX.
  - TX: emit 4 bytes MSB first, then →IDLE.
- TX handshake:
  - A byte is emitted only when `tx_busy`=0 and `tx_byte_rdy` was 0 on the previous cycle, so strobes are at least 2 cycles apart.
  - While `tx_busy`=1 the block stalls indefinitely; there is no timeout in TX.
- `rx_byte_rdy` is ignored in WR, RD, RD_WAIT and TX. Those bytes are dropped, not queued.
- `lb_rd_rdy` outside RD_WAIT, and on the same cycle as `lb_rd`, is ignored.
- `lb_rd_rdy` on the same cycle the counter hits `rd_timeout`: the real data wins and `rd_to_err` is not pulsed.

## Timing
- Reset values: all outputs 0; state IDLE; shift registers 0.
- Reset mid-operation: the command is abandoned; no `lb_wr`, `lb_rd` or `tx_byte_rdy` is asserted on the cycle after `reset` falls.
- Write latency: `lb_wr` is high on the cycle after the 8th data strobe. `lb_addr` and `lb_wr_d` are already valid on that cycle.
- Read latency: `lb_rd` is high on the cycle after the 4th address strobe.
- Read data: the first `tx_byte_rdy` comes no earlier than 1 cycle after `lb_rd_rdy`.
- Timeout: with no response, `rd_to_err` pulses exactly `rd_timeout` cycles after the `lb_rd` cycle.
- Back-to-back commands: a new command byte is accepted the cycle after WR, or the cycle after the last TX strobe.

## Structure
- Shared package `lb_master_pkg`:
  - CMD_WR=8'h57, CMD_RD=8'h52, TIMEOUT_DATA=32'hDEADBEEF.
  - State encoding localparams (3 bits).
- One sub-module, `lb_byte_ser`: a 32-bit to 4-byte serializer implementing the TX handshake, with `load`, `din[31:0]` and `done` ports. Everything else stays in `lb_master`.

## Test plan
- Write: send 57 00 00 00 04 12 34 56 78 → one `lb_wr` pulse with `lb_addr`=0x00000004 and `lb_wr_d`=0x12345678; no tx bytes.
- Read: send 52 00 00 00 00; responder returns 0xCAFEF00D 3 cycles after `lb_rd` → tx bytes CA FE F0 0D, one `lb_rd` pulse total.
- Timeout: with `rd_timeout`=16 and no `lb_rd_rdy` → `rd_to_err` pulses 16 cycles after `lb_rd`, then tx bytes DE AD BE EF.
- Flow control: hold `tx_busy`=1 for 50 cycles during a read reply → no strobe while busy, all 4 bytes in order afterwards, strobes ≥2 cycles apart.
- Junk and drops:
  - Send 00 FF then a valid write → only the write executes.
  - Send rx bytes during RD_WAIT → they are dropped and the next command is still parsed correctly.
- Reset mid-op: assert `reset` after 3 address bytes → all outputs 0, no bus strobe; a following complete write executes normally.
